// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data, one access at a time; data wins except at the starvation limit.
// Access latency 1 cycle plus one cycle per low mem_ready; requests are held off until the completion edge.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_ACC = 2'd1;
  localparam logic [1:0] DM_ACC = 2'd2;
  localparam logic [3:0] LIM    = 4'(STARVE_LIM);

  logic [1:0]        state;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              busy;
  logic              arb_en;
  logic              dm_win;
  logic              if_win;

  assign busy   = (state == IF_ACC) || (state == DM_ACC);
  // Arbitrate when idle or on the completion edge, giving back-to-back accesses with no bubble.
  assign arb_en = !busy || mem_ready;
  assign dm_win = dm_req && !(if_req && (starve_cnt == LIM));
  assign if_win = !dm_win && if_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else if (arb_en) begin
      if (dm_win) begin
        state      <= DM_ACC;
        addr_q     <= dm_addr;
        wdata_q    <= dm_wdata;
        we_q       <= dm_we;
        starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
      end else if (if_win) begin
        state      <= IF_ACC;
        addr_q     <= if_addr;
        starve_cnt <= 4'd0;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign mem_en    = busy;
  assign mem_we    = (state == DM_ACC) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state == IF_ACC) && mem_ready;
  assign dm_ack    = (state == DM_ACC) && mem_ready;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory port between the fetch stage and the memory (load/store) stage of the MIPS pipeline. It sequences one access at a time, latches the winning request, waits on the memory's `mem_ready` handshake and returns a per-requester acknowledge. Data accesses have priority, with a bounded-starvation rule that guarantees fetch progress. It sits between fetch control / the PC path and the pipeline's memory stage on one side and the memory macro on the other.

## Interface

Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIM`, 3, maximum consecutive data grants while fetch waits (range 1..15)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  fetch access complete, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_ack`  out  1  data access complete, `dm_rdata` valid on loads
- `dm_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ready`  in  1  memory completes the current access this cycle

## Operation

- States: IDLE, IF_ACC, DM_ACC. Reset state IDLE.
- Arbitration is evaluated at every rising edge where state is IDLE, or where state is IF_ACC/DM_ACC and `mem_ready`=1 (completion edge):
  - `dm_req`=1 and not (`if_req`=1 and `starve_cnt`==STARVE_LIM) -> DM_ACC
  - else `if_req`=1 -> IF_ACC
  - else -> IDLE
- On the grant edge the winner's address (and for data, `dm_we`, `dm_wdata`) is latched into internal registers; `mem_addr`, `mem_we`, `mem_wdata` drive from these registers.
- `mem_en` = 1 in IF_ACC and DM_ACC; `mem_we` = latched `dm_we` in DM_ACC, 0 otherwise.
- `if_ack` = (state==IF_ACC) & `mem_ready`; `dm_ack` = (state==DM_ACC) & `mem_ready` (combinational).
- `if_rdata` and `dm_rdata` pass `mem_rdata` through; valid only while the matching ack is high.
- A request held high on its own ack cycle is treated as a new request at that completion edge (pipelined back-to-back, no bubble).
- Requester contract: hold `*_req` high until ack. Dropping it mid-access does not abort; the access completes and the ack still pulses.
- Input changes after the grant edge have no effect on the current access.
- `starve_cnt` (4 bits):
  - DM grant with `if_req`=1 -> +1
  - IF grant, or DM grant with `if_req`=0 -> 0
  - no grant -> hold

## Timing

- Reset (async, `rst`=0): state IDLE; `starve_cnt`=0; latched addr/wdata/we = 0. Hence `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_ack`=0, `dm_ack`=0 immediately, independent of `clk`.
- Reset mid-access abandons the access with no ack. After release, arbitration restarts from IDLE at the first edge.
- Latency from IDLE:
  - request sampled at edge N; `mem_en` high in cycle N..N+1
  - with `mem_ready`=1 in that cycle, ack is in the same cycle: one-cycle access
  - each low-`mem_ready` cycle adds one cycle
- Throughput: one access per cycle when `mem_ready` is held 1 and requests stay high.
- While `mem_ready`=0, all `mem_*` outputs are held stable.
- Both requests arriving at the same edge: DM wins unless the starvation limit is reached.
- `if_ack` and `dm_ack` are never high in the same cycle.

## Test plan

- Reset: drive `rst`=0 during DM_ACC with `mem_we`=1 -> `mem_en`, `mem_we`, acks fall to 0 without a clock edge. After release with no requests, outputs stay 0.
- Single fetch:
  - stimulus: `if_req`=1, `if_addr`=0x00400000; `mem_ready`=1, `mem_rdata`=0x8C080004
  - response: next cycle `mem_en`=1, `mem_addr`=0x00400000, `mem_we`=0, `if_ack`=1, `if_rdata`=0x8C080004
- Simultaneous requests:
  - stimulus: `if_req`, `dm_req` both rise at one edge; store `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF; `mem_ready`=1
  - response: DM_ACC first with `mem_we`=1, `mem_wdata`=0xDEADBEEF; IF_ACC the very next cycle, no idle bubble
- Starvation, `STARVE_LIM`=3: both requests held high, `mem_ready`=1 -> grant sequence D,D,D,I,D,D,D,I; `starve_cnt` returns to 0 after each I.
- Wait states:
  - stimulus: DM load, `mem_ready`=0 for 3 cycles, then 1; change `dm_addr` during the wait
  - response: `mem_addr` holds the latched value; `dm_ack` only on cycle 4 of the access; `dm_rdata`=`mem_rdata` in that cycle
- Dropped request: `if_req` deasserted during IF_ACC wait -> access completes, `if_ack` pulses once, then IDLE.
